// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter among N_REQ byte streams.
// Grants a requester for a whole packet, then feeds its bytes to the transmitter one frame at a time.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               active
);

  localparam int unsigned IDX_W    = $clog2(N_REQ);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               last_q, last_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [N_REQ-1:0]   grant_d, ready_d;
  logic [7:0]         data_d;
  logic               start_d, active_d;

  logic [IDX_W-1:0]   pick, pick_hi, pick_lo;
  logic               hi_found;
  logic               owner_valid, owner_last;
  logic [7:0]         owner_data;

  // Round-robin search: lowest valid index at or above rr, else lowest valid index overall
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_lo = IDX_W'(i);
        if (IDX_W'(i) >= rr_q) begin
          pick_hi  = IDX_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    pick = hi_found ? pick_hi : pick_lo;

    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == owner_q) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[8*i +: 8];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      grant     <= '0;
      req_ready <= '0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      active    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      grant     <= grant_d;
      req_ready <= ready_d;
      tx_data   <= data_d;
      tx_start  <= start_d;
      active    <= active_d;
    end
  end

  // Next-state logic; tx_done outside WAIT is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|req_valid) state_d = S_LOAD;
      S_LOAD:  if (owner_valid) state_d = S_START;
      S_START: if (tx_busy) state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          if (GAP_CYCLES == 0) state_d = last_q ? S_IDLE : S_LOAD;
          else                 state_d = S_GAP;
        end
      end
      S_GAP:   if (gap_q == '0) state_d = last_q ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of registered outputs and datapath, keyed off the transition taken
  always_comb begin
    owner_d = owner_q;
    rr_d    = rr_q;
    last_d  = last_q;
    gap_d   = gap_q;
    grant_d = grant;
    data_d  = tx_data;
    ready_d = '0;

    if (state_q == S_IDLE && state_d == S_LOAD) begin
      owner_d = pick;
      for (int i = 0; i < N_REQ; i++) grant_d[i] = (IDX_W'(i) == pick);
    end

    if (state_q == S_LOAD && state_d == S_START) begin
      data_d = owner_data;
      last_d = owner_last;
    end

    if (state_d == S_GAP && state_q != S_GAP) gap_d = GAP_W'(GAP_LOAD);
    else if (state_q == S_GAP)                gap_d = gap_q - GAP_W'(1);

    if (state_d == S_IDLE && state_q != S_IDLE) begin
      grant_d = '0;
      rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    end

    if (state_d == S_LOAD) begin
      for (int i = 0; i < N_REQ; i++) ready_d[i] = (IDX_W'(i) == owner_d);
    end

    start_d  = (state_d == S_START);
    active_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, behavioural transmitter,
// table of multi-requester packet vectors plus hand-written stall, gap and reset sequences.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam int GAP   = 10;
  localparam int FRAME = 6;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_REQ-1:0]  req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]  req_last;
  logic [N_REQ-1:0]  req_ready;
  logic [N_REQ-1:0]  grant;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              tx_done;
  logic              active;

  int n_vec  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .active    (active)
  );

  always #5 clk = ~clk;

  // Requester sources: {last, data} per lane
  logic [8:0] src_q [N_REQ][$];
  event kick;

  always @(kick) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    #1 -> kick;
  end

  // Transmitter model: busy one cycle after start, FRAME+1 busy cycles, then a tx_done pulse
  logic [3:0] log_g [$];
  logic [7:0] log_d [$];
  int frame_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      frame_cnt <= 0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy && tx_start) begin
        tx_busy   <= 1'b1;
        frame_cnt <= FRAME;
        log_g.push_back(grant);
        log_d.push_back(tx_data);
      end else if (tx_busy) begin
        if (frame_cnt == 0) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: no event within %0d cycles", name, BUDGET);
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(queues_empty() && !active && !tx_busy) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) timeout_fail(name);
  endtask

  task automatic push(input int lane, input logic last, input logic [7:0] d);
    src_q[lane].push_back({last, d});
  endtask

  task automatic clear_log();
    log_g.delete();
    log_d.delete();
  endtask

  task automatic check_log(input string name, input int k, input logic [3:0] eg, input logic [7:0] ed);
    if (k < log_g.size()) begin
      check($sformatf("%s grant[%0d]", name, k), 32'(log_g[k]), 32'(eg));
      check($sformatf("%s data[%0d]", name, k), 32'(log_d[k]), 32'(ed));
    end
  endtask

  function automatic logic [7:0] dat(input int v, input int i);
    return 8'hA5 ^ {4'(v), 4'(i)};
  endfunction

  // mask of lanes each sending one 1-byte packet, expected grant order packed 2 bits per packet
  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] cnt;
    logic [7:0] ord;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic ok;
    logic [1:0] o;
    logic [3:0] eg;

    vt[0] = {4'b0001, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    vt[1] = {4'b1111, 3'd4, 2'd0, 2'd3, 2'd2, 2'd1};
    vt[2] = {4'b0101, 3'd2, 2'd0, 2'd0, 2'd0, 2'd2};
    vt[3] = {4'b1001, 3'd2, 2'd0, 2'd0, 2'd0, 2'd3};
    vt[4] = {4'b0010, 3'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    vt[5] = {4'b0011, 3'd2, 2'd0, 2'd0, 2'd1, 2'd0};
    vt[6] = {4'b1000, 3'd1, 2'd0, 2'd0, 2'd0, 2'd3};
    vt[7] = {4'b0110, 3'd2, 2'd0, 2'd0, 2'd2, 2'd1};
    vt[8] = {4'b1111, 3'd4, 2'd2, 2'd1, 2'd0, 2'd3};

    rst_n = 1'b0;
    -> kick;
    repeat (3) @(negedge clk);
    check("rst grant", 32'(grant), 32'h0);
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst tx_start", 32'(tx_start), 32'h0);
    check("rst tx_data", 32'(tx_data), 32'h0);
    check("rst active", 32'(active), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of 1-byte packet mixes; rr carries over from one vector to the next
    for (int v = 0; v < 9; v++) begin
      clear_log();
      for (int i = 0; i < N_REQ; i++) if (vt[v].mask[i]) push(i, 1'b1, dat(v, i));
      -> kick;
      wait_idle($sformatf("vec%0d idle", v));
      check($sformatf("vec%0d frames", v), 32'(log_g.size()), 32'(vt[v].cnt));
      for (int k = 0; k < int'(vt[v].cnt); k++) begin
        o  = vt[v].ord[2*k +: 2];
        eg = 4'b0001 << o;
        check_log($sformatf("vec%0d", v), k, eg, dat(v, int'(o)));
      end
    end

    // Atomicity: req2 3-byte packet, req0/req1 arrive mid-packet (rr=3)
    clear_log();
    push(2, 1'b0, 8'h11); push(2, 1'b0, 8'h22); push(2, 1'b1, 8'h33);
    -> kick;
    n = 0;
    while (grant !== 4'b0100 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout_fail("atomic grant");
    push(0, 1'b1, 8'h44); push(1, 1'b1, 8'h55);
    -> kick;
    wait_idle("atomic idle");
    check("atomic frames", 32'(log_g.size()), 32'd5);
    check_log("atomic", 0, 4'b0100, 8'h11);
    check_log("atomic", 1, 4'b0100, 8'h22);
    check_log("atomic", 2, 4'b0100, 8'h33);
    check_log("atomic", 3, 4'b0001, 8'h44);
    check_log("atomic", 4, 4'b0010, 8'h55);

    // Gap and stall: req2 sends one byte, then withholds the rest of the packet (rr=2)
    clear_log();
    push(2, 1'b0, 8'hAA);
    -> kick;
    n = 0;
    while (tx_done !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout_fail("gap tx_done");
    n = 0;
    @(negedge clk);
    while (req_ready === 4'b0000 && n < 100) begin n++; @(negedge clk); end
    check("gap cycles", 32'(n), 32'(GAP));
    check("gap ready owner", 32'(req_ready), 32'b0100);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || grant !== 4'b0100 || req_ready !== 4'b0100) ok = 1'b0;
    end
    check("stall hold", 32'(ok), 32'd1);
    push(2, 1'b1, 8'hBB);
    -> kick;
    wait_idle("stall idle");
    check("stall frames", 32'(log_g.size()), 32'd2);
    check_log("stall", 0, 4'b0100, 8'hAA);
    check_log("stall", 1, 4'b0100, 8'hBB);

    // Reset during WAIT of a req3 packet (rr=3)
    push(3, 1'b0, 8'hC1); push(3, 1'b1, 8'hC2);
    -> kick;
    n = 0;
    while (!(tx_busy && !tx_start && grant === 4'b1000) && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) timeout_fail("reset wait state");
    rst_n = 1'b0;
    #1;
    check("midrst grant", 32'(grant), 32'h0);
    check("midrst req_ready", 32'(req_ready), 32'h0);
    check("midrst tx_start", 32'(tx_start), 32'h0);
    check("midrst tx_data", 32'(tx_data), 32'h0);
    check("midrst active", 32'(active), 32'h0);
    for (int i = 0; i < N_REQ; i++) src_q[i].delete();
    -> kick;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    push(1, 1'b1, 8'h5A); push(3, 1'b1, 8'h3C);
    -> kick;
    @(negedge clk);
    check("post grant", 32'(grant), 32'b0010);
    check("post req_ready", 32'(req_ready), 32'b0010);
    check("post active", 32'(active), 32'd1);
    @(negedge clk);
    check("post tx_start", 32'(tx_start), 32'd1);
    check("post tx_data", 32'(tx_data), 32'h5A);
    check("post ready drop", 32'(req_ready), 32'h0);
    wait_idle("post idle");
    check("post frames", 32'(log_g.size()), 32'd2);
    check_log("post", 0, 4'b0010, 8'h5A);
    check_log("post", 1, 4'b1000, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter and sequencer that shares one UART transmitter among `N_REQ` byte-stream requesters. Each requester presents bytes on a valid/ready interface with a `last` marker. The arbiter grants the UART to one requester for a whole packet and feeds bytes one at a time. It drives the transmitter's `data_in`/`tx_start` and paces itself from the transmitter's `busy`/`tx_done`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 0: idle clk cycles inserted after each `tx_done` before the next byte or arbitration; 0 means no gap.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low. Clock is `clk`.
- `req_valid` in N_REQ: requester i has a byte on `req_data[8*i+:8]`.
- `req_data` in 8*N_REQ: byte lanes.
- `req_last` in N_REQ: marks the final byte of requester i's packet. Sampled with the byte.
- `req_ready` out N_REQ: byte accepted from requester i when `req_valid[i] & req_ready[i]`.
- `grant` out N_REQ: one-hot current owner, or all zero.
- `tx_data` out 8: byte to transmitter `data_in`.
- `tx_start` out 1: start request to transmitter.
- `tx_busy` in 1: transmitter busy.
- `tx_done` in 1: transmitter one-cycle frame-complete pulse.
- `active` out 1: high whenever the state is not IDLE.

## Operation
- **Reset values:** state IDLE; `grant`=0, `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `active`=0; round-robin pointer `rr`=0.
- **Priority rule:** `rr` holds the index checked first. Requesters are searched `rr`, `rr+1`, … `mod N_REQ`.
- **IDLE**
  - Requires at least one `req_valid` set.
  - Choose the first valid index in `rr` order and latch it as `owner`.
  - Set `grant` to one-hot(`owner`) and go to LOAD.
- **LOAD**
  - `req_ready[owner]`=1. All other `req_ready` bits are 0.
  - On `req_valid[owner]`: latch `tx_data` from lane `owner` and latch `last` from `req_last[owner]`, then go to START.
  - If `req_valid[owner]` is low, remain in LOAD and keep the grant. There is no timeout. Other requesters are ignored.
- **START**
  - `tx_start`=1.
  - On the first cycle with `tx_busy`=1, go to WAIT. `tx_start` is 0 from WAIT onward.
- **WAIT**
  - Await `tx_done`=1.
  - Then go to GAP, or skip GAP when `GAP_CYCLES`=0.
- **GAP**
  - Count `GAP_CYCLES` cycles.
  - On exit:
    - If `last`=1: set `rr`=(`owner`+1) mod `N_REQ`, clear `grant`, go to IDLE.
    - If `last`=0: go to LOAD with the same owner.
  - When `GAP_CYCLES`=0, these exit actions occur on the `tx_done` cycle.
- **Data stability:** `tx_data` is stable from LOAD exit until the next LOAD acceptance.
- **`grant`:** never changes within a packet.
- **`req_ready`:** high only in LOAD, and only for the owner.

## Timing
- IDLE with `req_valid` seen at cycle t: `grant` registered at t+1, `req_ready` high at t+1.
- Byte accepted in LOAD at cycle t: `tx_start`=1 from t+1.
- `tx_start` deasserts the cycle after `tx_busy` is first sampled high.
  - The transmitter may see `tx_start` late through its input synchronizer. That is harmless, because it is past its idle state by then.
- START is entered only after the previous frame's `tx_done`, plus at least one LOAD cycle. So `tx_busy` from the prior frame has already dropped.
- A 1-byte packet with `GAP_CYCLES`=0 occupies: 1 IDLE cycle + 1 LOAD cycle + transmitter start latency + frame time.
- A new arbitration may begin the cycle after the return to IDLE.
- **Simultaneous events:**
  - `tx_done` while in START (transmitter protocol error): ignored.
  - New `req_valid` bits during a packet do not preempt the owner.
- **Reset mid-frame:** all outputs return to reset values immediately, including `tx_start`=0 and `grant`=0. Partial packets are abandoned.

## Test plan
- **Single byte:** req0 sends 8'hA5 with last=1 → `grant`=4'b0001. Exactly one `tx_start` episode occurs, `tx_data`=8'hA5, return to IDLE after `tx_done`, `rr`=1.
- **Fairness:** all 4 requesters continuously send 1-byte packets → grants are in order 0,1,2,3,0. No requester is granted twice before the others.
- **Packet atomicity:** req2 sends 3 bytes 11,22,33 (last on 33) while req0 and req1 are also valid → bytes 11,22,33 go out consecutively under `grant`=4'b0100, then `grant` moves to req3 or wraps to req0 per `rr`.
- **Stall:** owner drops `req_valid` for 50 cycles mid-packet → arbiter holds LOAD and the grant, `tx_start` stays 0, and the packet resumes without loss.
- **Gap:** with `GAP_CYCLES`=10, a 2-byte packet → exactly 10 cycles between `tx_done` and the next `req_ready`.
- **Reset mid-frame:** assert `rst_n`=0 during WAIT → all outputs are 0 within the same cycle. After release, a fresh packet from req1 is granted first (`rr`=0, req0 idle).
